fir_output_buffer: RTL and testbench
====================================

Name: fir_output_buffer

Overview:
Downstream stage of the FIR core controller/datapath. The core pulses its output-valid for exactly one cycle and cannot stall. This block therefore captures each filter result into a small FIFO and re-presents it on a valid/ready stream to the consumer. It also tracks samples in flight inside the core and drives a credit gate upstream, so the core never produces a result the buffer cannot hold.

Parameters:
DATA_WIDTH, 32, width of one filter result.
DEPTH, 4, FIFO entries; power of two, >= 2.
MAX_INFLIGHT, 1, maximum samples the core may hold between accept and output pulse.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
core_result  in  DATA_WIDTH  filter result; valid only when core_output_valid=1.
core_output_valid  in  1  one-cycle pulse from the core controller in its output state.
core_sample_accept  in  1  one-cycle pulse when the core takes a sample (upstream input_valid && core ready_for_input).
accept_enable  out  1  credit gate; upstream must AND its input_valid with this.
m_data  out  DATA_WIDTH  head-of-FIFO result.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer ready.
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky error flag.

Behaviour:
- Reset (async, immediate):
  - wr_ptr = rd_ptr = 0, count = 0, inflight = 0.
  - m_valid = 0, m_data = 0, overflow = 0.
  - accept_enable = 1.
  - Storage array is not reset.
- Write: on any clk edge with core_output_valid=1 and the write allowed, mem[wr_ptr] <= core_result and wr_ptr increments.
- Read: on any clk edge with m_valid && m_ready, rd_ptr increments.
- Pointer wrap: both pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Show-ahead: m_data = mem[rd_ptr] when m_valid=1, else 0. m_valid = (count != 0).
- Latency: a result written at edge N appears on m_valid/m_data immediately after edge N, i.e. one-cycle write-to-visible.
- Write allowed: count < DEPTH, OR a read occurs in the same cycle (full with simultaneous read: write accepted, count unchanged).
- Overflow: core_output_valid when full and no read that cycle.
  - Result is dropped; pointers and count unchanged.
  - overflow <= 1 and holds until reset.
- Count update: count_next = count + write_accepted - read.
  - Simultaneous write+read when empty: the write lands, the read cannot occur (m_valid=0), so count becomes 1.
- Inflight counter (0..MAX_INFLIGHT): inflight_next = inflight + core_sample_accept - core_output_valid.
  - Simultaneous accept and output pulse: unchanged.
  - An output pulse with inflight=0 saturates at 0 (no underflow).
  - An accept with inflight=MAX_INFLIGHT saturates.
- accept_enable = (count + inflight < DEPTH), computed combinationally from registered count and inflight only (no combinational path from inputs).
  - Guarantees a slot for every accepted sample, provided upstream honours the gate.
- m_ready with m_valid=0 has no effect.
- Reset mid-operation: all buffered and in-flight data is discarded. The core controller is reset by the same signal.

Decomposition:
- fir_pkg (shared): DATA_WIDTH default constant, and a result_t typedef (logic [DATA_WIDTH-1:0]) also used by the core datapath.
- One sub-module, fir_credit_counter: the saturating inflight up/down counter plus the accept_enable compare. Parameters MAX_INFLIGHT and DEPTH; inputs count, accept, release.
- FIFO storage and pointers stay in the top module.

Test Plan:
- Reset with no stimulus -> m_valid=0, m_data=0, count=0, accept_enable=1, overflow=0.
- core_sample_accept pulse, then 3 cycles later core_output_valid with core_result=32'h0000_1234 and m_ready=0:
  - inflight goes 1 then 0; count=1.
  - m_valid=1, m_data=32'h1234 the cycle after the pulse.
- Four results 1,2,3,4 with m_ready=0 (DEPTH=4):
  - count=4, accept_enable=0.
  - Raise m_ready -> data pops 1,2,3,4 on consecutive cycles, then m_valid=0.
- Full FIFO, core_output_valid=5 with m_ready=1 in the same cycle:
  - 1 is read and 5 is written; count stays 4; no overflow.
  - Drain order is 2,3,4,5.
- Full FIFO, core_output_valid=9 with m_ready=0 -> result dropped, overflow=1 and stays 1; count=4; head still the oldest entry.
- Three results buffered plus one accepted sample in flight -> accept_enable=0. Assert reset mid-stream -> all outputs return to reset values asynchronously, and accept_enable=1 after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default result width and the result type used by
// both the core datapath and the output buffer.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 32;

    typedef logic [FIR_DATA_WIDTH-1:0] result_t;

endpackage : fir_pkg

// File: rtl/fir_credit_counter.sv
// Tracks samples held inside the FIR core and gates new accepts so that every
// accepted sample is guaranteed a free slot in the output FIFO.
module fir_credit_counter
    import fir_pkg::*;
#(
    parameter int MAX_INFLIGHT = 1,
    parameter int DEPTH        = 4,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] count_i,
    input  logic          accept_i,
    input  logic          release_i,
    output logic [IW-1:0] inflight_o,
    output logic          accept_enable_o
);

    localparam int SW = CW + IW;
    localparam logic [IW-1:0] MAX_Q = IW'(MAX_INFLIGHT);

    logic [IW-1:0] inflight_q;
    logic [IW-1:0] inflight_d;
    logic [SW-1:0] occupancy_s;

    // Saturating up/down: simultaneous accept and release cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept_i, release_i})
            2'b10: begin
                if (inflight_q < MAX_Q) begin
                    inflight_d = inflight_q + IW'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            2'b01: begin
                if (inflight_q != IW'(0)) begin
                    inflight_d = inflight_q - IW'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // In-flight counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= IW'(0);
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Gate depends on registered state only, never on this cycle's inputs.
    always_comb begin
        occupancy_s     = SW'(count_i) + SW'(inflight_q);
        accept_enable_o = (occupancy_s < SW'(DEPTH));
    end

    assign inflight_o = inflight_q;

endmodule : fir_credit_counter

// File: rtl/fir_output_buffer.sv
// Captures one-cycle result pulses from the non-stallable FIR core into a small
// show-ahead FIFO and re-presents them on a valid/ready stream.
module fir_output_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH   = FIR_DATA_WIDTH,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 1,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] core_result,
    input  logic                  core_output_valid,
    input  logic                  core_sample_accept,
    output logic                  accept_enable,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full_s, rd_s, wr_s, drop_s;
    logic [IW-1:0]         inflight_s;

    // Write/read qualification; a full FIFO still takes a write when it pops.
    always_comb begin
        full_s = (count_q == CW'(DEPTH));
        rd_s   = (count_q != CW'(0)) && m_ready;
        wr_s   = core_output_valid && (!full_s || rd_s);
        drop_s = core_output_valid && full_s && !rd_s;
    end

    // Next-state for pointers, occupancy and sticky overflow.
    always_comb begin
        count_d = count_q;
        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        overflow_d = overflow_q | drop_s;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= PW'(0);
            rd_ptr_q   <= PW'(0);
            count_q    <= CW'(0);
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left unreset; valid tracking lives in count_q.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= core_result;
        end
    end

    // Show-ahead head; forced to zero while empty so stale data never leaks.
    always_comb begin
        m_valid = (count_q != CW'(0));
        if (m_valid) begin
            m_data = mem_q[rd_ptr_q];
        end else begin
            m_data = '0;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

    fir_credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .DEPTH        (DEPTH)
    ) u_credit (
        .clk             (clk),
        .reset           (reset),
        .count_i         (count_q),
        .accept_i        (core_sample_accept),
        .release_i       (core_output_valid),
        .inflight_o      (inflight_s),
        .accept_enable_o (accept_enable)
    );

endmodule : fir_output_buffer

// File: tb/tb_fir_output_buffer.sv
// Randomized and directed bench for fir_output_buffer against a queue-based
// reference model of the buffer and credit rules.
module tb_fir_output_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXI  = 1;

    logic          clk;
    logic          reset;
    logic [DW-1:0] core_result;
    logic          core_output_valid;
    logic          core_sample_accept;
    logic          accept_enable;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    count;
    logic          overflow;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [DW-1:0] mdl_q[$];
    int            mdl_inf;
    logic          mdl_ovf;

    fir_output_buffer #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .core_result        (core_result),
        .core_output_valid  (core_output_valid),
        .core_sample_accept (core_sample_accept),
        .accept_enable      (accept_enable),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .count              (count),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_inf = 0;
        mdl_ovf = 1'b0;
    endtask

    function automatic logic exp_ae();
        return (mdl_q.size() + mdl_inf) < DEPTH;
    endfunction

    task automatic check_all();
        check_eq("m_valid", 64'(m_valid), 64'(mdl_q.size() != 0));
        check_eq("m_data", 64'(m_data), (mdl_q.size() != 0) ? 64'(mdl_q[0]) : 64'd0);
        check_eq("count", 64'(count), 64'(mdl_q.size()));
        check_eq("accept_enable", 64'(accept_enable), 64'(exp_ae()));
        check_eq("overflow", 64'(overflow), 64'(mdl_ovf));
        check_eq("inflight", 64'(dut.u_credit.inflight_o), 64'(mdl_inf));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic acc, input logic ov, input logic [DW-1:0] res, input logic rdy);
        bit rd;
        bit full;
        core_sample_accept = acc;
        core_output_valid  = ov;
        core_result        = res;
        m_ready            = rdy;
        @(posedge clk);
        rd   = (mdl_q.size() != 0) && rdy;
        full = (mdl_q.size() == DEPTH);
        if (rd) void'(mdl_q.pop_front());
        if (ov) begin
            if (!full || rd) mdl_q.push_back(res);
            else mdl_ovf = 1'b1;
        end
        if (acc && !ov) mdl_inf = (mdl_inf < MAXI) ? mdl_inf + 1 : mdl_inf;
        else if (!acc && ov && mdl_inf > 0) mdl_inf = mdl_inf - 1;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        core_result        = '0;
        core_output_valid  = 1'b0;
        core_sample_accept = 1'b0;
        m_ready            = 1'b0;
        model_reset();
        #2;
        do_reset();
        check_eq("rst_ae", 64'(accept_enable), 64'd1);
        check_eq("rst_mdata", 64'(m_data), 64'd0);

        // Accept, three idle-ish cycles, then the output pulse.
        step(1'b1, 1'b0, '0, 1'b0);
        check_eq("inflight_up", 64'(dut.u_credit.inflight_o), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_1234, 1'b0);
        check_eq("first_data", 64'(m_data), 64'h1234);
        check_eq("first_cnt", 64'(count), 64'd1);
        check_eq("inflight_dn", 64'(dut.u_credit.inflight_o), 64'd0);

        // Fill with 1..4 and drain in order.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        check_eq("full_cnt", 64'(count), 64'd4);
        check_eq("full_ae", 64'(accept_enable), 64'd0);
        check_eq("full_head", 64'(m_data), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            check_eq("drain_data", 64'(m_data), 64'(i));
        end
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("drain_empty", 64'(m_valid), 64'd0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Full plus simultaneous read and write.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        step(1'b0, 1'b1, 32'd5, 1'b1);
        check_eq("rw_cnt", 64'(count), 64'd4);
        check_eq("rw_ovf", 64'(overflow), 64'd0);
        check_eq("rw_head", 64'(m_data), 64'd2);

        // Full with no read: drop and sticky overflow.
        step(1'b0, 1'b1, 32'd9, 1'b0);
        check_eq("ovf_set", 64'(overflow), 64'd1);
        check_eq("ovf_cnt", 64'(count), 64'd4);
        check_eq("ovf_head", 64'(m_data), 64'd2);
        for (int i = 2; i <= 5; i++) begin
            check_eq("ovf_drain", 64'(m_data), 64'(i));
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check_eq("ovf_sticky", 64'(overflow), 64'd1);

        // Write into empty with ready high: count becomes 1.
        do_reset();
        step(1'b0, 1'b1, 32'hABCD, 1'b1);
        check_eq("empty_rw_cnt", 64'(count), 64'd1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Three buffered plus one in flight closes the gate; async reset mid-cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check_eq("gate_closed", 64'(accept_enable), 64'd0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check_eq("async_cnt", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("post_rst_ae", 64'(accept_enable), 64'd1);

        // Well-behaved random traffic: the gate is honoured, so no overflow.
        for (int n = 0; n < 600; n++) begin
            logic acc, ov, rdy;
            acc = ($urandom_range(0, 1) == 1) && exp_ae();
            ov  = (mdl_inf > 0) && ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(acc, ov, DW'($urandom), rdy);
        end
        check_eq("rand_no_ovf", 64'(overflow), 64'd0);

        // Unconstrained random traffic, including gate violations.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_fir_output_buffer
